// File: rtl/cpu_ctrl_pkg.sv
// Shared state codes for the CPU run controller and the LED display decoder.
// The numeric codes are what the display shows, so they must not be renumbered.
package cpu_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd1;
  localparam logic [ST_W-1:0] ST_PAUSE = 3'd2;
  localparam logic [ST_W-1:0] ST_STEP  = 3'd3;
  localparam logic [ST_W-1:0] ST_HALT  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_STEP  = ST_STEP,
    S_HALT  = ST_HALT
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Switch/button inputs and CPU-facing outputs of the run controller.
// No valid/ready handshake: switches are levels, cpu_en is a one-clk advance pulse.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);

  logic                         start_sw;
  logic                         pause_sw;
  logic                         step_btn;
  logic                         halt;
  logic                         cpu_en;
  logic                         cpu_rst;
  logic [cpu_ctrl_pkg::ST_W-1:0] state;
  logic [CNT_W-1:0]             cycle_count;

  // Board / CPU side: drives the switches and halt, observes the controller.
  modport master (
    output start_sw,
    output pause_sw,
    output step_btn,
    output halt,
    input  cpu_en,
    input  cpu_rst,
    input  state,
    input  cycle_count
  );

  // Controller side.
  modport slave (
    input  start_sw,
    input  pause_sw,
    input  step_btn,
    input  halt,
    output cpu_en,
    output cpu_rst,
    output state,
    output cycle_count
  );

endinterface

// File: rtl/btn_debounce.sv
// Accepts a new level on din only after it has differed from dout for DEBOUNCE
// consecutive cycles; rise pulses for one cycle when the accepted level goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (din == r_dout) begin
        // Any return to the accepted level restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_dout <= din;
        r_rise <= din;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step sequencer: produces the CPU clock-enable, holds the core in
// reset while idle, stops on halt and counts issued enable pulses.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter int DEBOUNCE = 500000,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_run_ctrl_if.slave     bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [1:0]       r_start_sync;
  logic [1:0]       r_pause_sync;
  logic [1:0]       r_step_sync;
  logic [DW-1:0]    r_div_cnt;
  run_state_e       r_state;
  logic             r_cpu_en;
  logic             r_cpu_rst;
  logic [CNT_W-1:0] r_cycle_count;

  logic w_start_s;
  logic w_pause_s;
  logic w_step_s;
  logic w_step_db;
  logic w_step_rise;
  logic w_step_req;
  logic w_tick;
  logic w_pulse;

  // Switches and button are asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_sync <= 2'b00;
      r_pause_sync <= 2'b00;
      r_step_sync  <= 2'b00;
    end else begin
      r_start_sync <= {r_start_sync[0], bus.start_sw};
      r_pause_sync <= {r_pause_sync[0], bus.pause_sw};
      r_step_sync  <= {r_step_sync[0],  bus.step_btn};
    end
  end

  assign w_start_s = r_start_sync[1];
  assign w_pause_s = r_pause_sync[1];
  assign w_step_s  = r_step_sync[1];

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_step_db (
    .clk  (clk),
    .rst  (rst),
    .din  (w_step_s),
    .dout (w_step_db),
    .rise (w_step_rise)
  );

  assign w_step_req = w_step_rise & w_step_db;

  // Divider restarts on every RUN entry so the first tick is a full period away.
  assign w_tick = (r_state == S_RUN) && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if ((r_state != S_RUN) || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // halt in the deciding cycle suppresses the pulse, even on a tick.
  assign w_pulse = !bus.halt && (((r_state == S_RUN) && w_tick) || (r_state == S_STEP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cpu_en      <= 1'b0;
      r_cpu_rst     <= 1'b1;
      r_cycle_count <= '0;
    end else begin
      r_cpu_rst <= (r_state == S_IDLE);
      r_cpu_en  <= w_pulse;

      if (r_state == S_IDLE) begin
        r_cycle_count <= '0;
      end else if (w_pulse && (r_cycle_count != {CNT_W{1'b1}})) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end

      if (!w_start_s) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  r_state <= S_RUN;
          S_RUN: begin
            if (bus.halt)       r_state <= S_HALT;
            else if (w_pause_s) r_state <= S_PAUSE;
          end
          S_PAUSE: begin
            if (bus.halt)        r_state <= S_HALT;
            else if (!w_pause_s) r_state <= S_RUN;
            else if (w_step_req) r_state <= S_STEP;
          end
          S_STEP:  r_state <= S_PAUSE;
          // Leaving HALT needs start_s to drop, handled above.
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.state       = r_state;
  assign bus.cpu_en      = r_cpu_en;
  assign bus.cpu_rst     = r_cpu_rst;
  assign bus.cycle_count = r_cycle_count;

endmodule
